// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared core constants for the write-back register file and scoreboard.
// Register-file geometry and the hard-wired zero register index.
package wb_regfile_scoreboard_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] ZERO_REG = '0;

    // True when a write-back is architecturally visible (x0 writes are dropped).
    function automatic logic wb_accepted(input logic reg_write, input logic [AW-1:0] rd);
        return reg_write && (rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_regfile_scoreboard_bits.sv
// Pending-write scoreboard: NREG-bit set/clear vector with flush and hazard lookup.
// Priority per bit: flush clears everything, otherwise a new issue beats a same-cycle write-back.
module regfile_scoreboard_bits
    import wb_regfile_scoreboard_pkg::*;
#(
    parameter int NREG = wb_regfile_scoreboard_pkg::NREG,
    parameter int AW   = wb_regfile_scoreboard_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            RegWrite,
    input  logic [AW-1:0]   rd_WB,
    input  logic            flush,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            hazard,
    output logic [NREG-1:0] pending_mask
);

    logic [NREG-1:0] pending_next;
    logic            haz1;
    logic            haz2;

    always_comb begin
        pending_next = pending_mask;
        for (int i = 1; i < NREG; i++) begin
            if (RegWrite && (rd_WB == AW'(i))) begin
                pending_next[i] = 1'b0;
            end
            if (issue_valid && (issue_rd == AW'(i))) begin
                pending_next[i] = 1'b1;
            end
        end
        if (flush) begin
            pending_next = '0;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_mask <= '0;
        end else begin
            pending_mask <= pending_next;
        end
    end

    // A write-back landing this cycle is forwarded, so it does not stall.
    always_comb begin
        haz1   = (rs1_addr != ZERO_REG) && pending_mask[rs1_addr]
                 && !(RegWrite && (rd_WB == rs1_addr));
        haz2   = (rs2_addr != ZERO_REG) && pending_mask[rs2_addr]
                 && !(RegWrite && (rd_WB == rs2_addr));
        hazard = rd_en && (haz1 || haz2);
    end

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Write-back consumer: 32-entry register file with bypassed registered reads plus scoreboard.
// Optional write-back counter output wb_count enabled by macro WB_REGFILE_WBCOUNT_EN.
module wb_regfile_scoreboard
    import wb_regfile_scoreboard_pkg::*;
#(
    parameter int XLEN = wb_regfile_scoreboard_pkg::XLEN,
    parameter int NREG = wb_regfile_scoreboard_pkg::NREG,
    parameter int AW   = wb_regfile_scoreboard_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rd_WB,
    input  logic            RegWrite,
    input  logic [XLEN-1:0] DataOut_WB,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            hazard,
`ifdef WB_REGFILE_WBCOUNT_EN
    output logic [31:0]     wb_count,
`endif
    output logic [NREG-1:0] pending_mask
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_accept;
    logic [XLEN-1:0] rs1_next;
    logic [XLEN-1:0] rs2_next;

    assign wr_accept = wb_accepted(RegWrite, rd_WB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_accept) begin
            regs[rd_WB] <= DataOut_WB;
        end
    end

    // Read mux: x0 forced to zero, then same-cycle write-back bypass, then the array.
    always_comb begin
        rs1_next = regs[rs1_addr];
        if (RegWrite && (rd_WB == rs1_addr)) begin
            rs1_next = DataOut_WB;
        end
        if (rs1_addr == ZERO_REG) begin
            rs1_next = '0;
        end
        rs2_next = regs[rs2_addr];
        if (RegWrite && (rd_WB == rs2_addr)) begin
            rs2_next = DataOut_WB;
        end
        if (rs2_addr == ZERO_REG) begin
            rs2_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1_data <= '0;
            rs2_data <= '0;
        end else if (rd_en) begin
            rs1_data <= rs1_next;
            rs2_data <= rs2_next;
        end
    end

`ifdef WB_REGFILE_WBCOUNT_EN
    // Counts every accepted write, flush or not; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count <= '0;
        end else if (wr_accept) begin
            wb_count <= wb_count + 32'd1;
        end
    end
`else
`endif

    regfile_scoreboard_bits #(
        .NREG (NREG),
        .AW   (AW)
    ) u_bits (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .RegWrite     (RegWrite),
        .rd_WB        (rd_WB),
        .flush        (flush),
        .rd_en        (rd_en),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .hazard       (hazard),
        .pending_mask (pending_mask)
    );

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: reset, writes, bypass, scoreboard, flush.
// Counter checks are included when WB_REGFILE_WBCOUNT_EN is defined.
module tb_wb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_WB;
    logic        RegWrite;
    logic [31:0] DataOut_WB;
    logic        rd_en;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        hazard;
    logic [31:0] pending_mask;
`ifdef WB_REGFILE_WBCOUNT_EN
    logic [31:0] wb_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_regfile_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .rd_WB        (rd_WB),
        .RegWrite     (RegWrite),
        .DataOut_WB   (DataOut_WB),
        .rd_en        (rd_en),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .hazard       (hazard),
`ifdef WB_REGFILE_WBCOUNT_EN
        .wb_count     (wb_count),
`endif
        .pending_mask (pending_mask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0; rd_WB = 5'd0; DataOut_WB = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        rd_en = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;

        // 1. reset
        repeat (2) tick();
        chk("reset_pending", pending_mask, 32'h0);
        chk("reset_rs1", rs1_data, 32'h0);
        rst = 1'b1;
        rd_en = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1 chk("reset_hazard", {31'd0, hazard}, 32'h0);
        tick();
        chk("post_reset_rs1", rs1_data, 32'h0);
        chk("post_reset_rs2", rs2_data, 32'h0);

        // 2. write then read, then hold with rd_en low
        rd_en = 1'b0;
        RegWrite = 1'b1; rd_WB = 5'd1; DataOut_WB = 32'h9876_5432;
        tick();
        idle();
        rd_en = 1'b1; rs1_addr = 5'd1; rs2_addr = 5'd0;
        tick();
        chk("wr_rd_rs1", rs1_data, 32'h9876_5432);
        chk("wr_rd_rs2_x0", rs2_data, 32'h0);
        rd_en = 1'b0; rs1_addr = 5'd5;
        tick();
        chk("hold_rs1", rs1_data, 32'h9876_5432);

        // 3. bypass, and x0 write dropped
        rd_en = 1'b1; rs1_addr = 5'd1; rs2_addr = 5'd3;
        RegWrite = 1'b1; rd_WB = 5'd3; DataOut_WB = 32'h0BAD_C0DE;
        tick();
        chk("bypass_rs2", rs2_data, 32'h0BAD_C0DE);
        chk("bypass_rs1_other", rs1_data, 32'h9876_5432);
        rd_WB = 5'd0; DataOut_WB = 32'hDEAD_BEEF; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        chk("x0_bypass_blocked", rs1_data, 32'h0);
        idle();
        rs1_addr = 5'd0; rs2_addr = 5'd3;
        tick();
        chk("x0_array_zero", rs1_data, 32'h0);
        chk("array_rs2_x3", rs2_data, 32'h0BAD_C0DE);
        rs1_addr = 5'd3;
        tick();
        chk("same_reg_rs1", rs1_data, 32'h0BAD_C0DE);
        chk("same_reg_rs2", rs2_data, 32'h0BAD_C0DE);

        // 4. scoreboard set, hazard, resolve through bypass
        rd_en = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle();
        chk("sb_set7", pending_mask, 32'h0000_0080);
        rd_en = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd0;
        #1 chk("hazard_rs1", {31'd0, hazard}, 32'h1);
        rs1_addr = 5'd0; rs2_addr = 5'd7;
        #1 chk("hazard_rs2", {31'd0, hazard}, 32'h1);
        rd_en = 1'b0;
        #1 chk("hazard_no_rden", {31'd0, hazard}, 32'h0);
        rd_en = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd0;
        RegWrite = 1'b1; rd_WB = 5'd7; DataOut_WB = 32'h0000_0077;
        #1 chk("hazard_resolved", {31'd0, hazard}, 32'h0);
        tick();
        idle();
        chk("sb_clear7", pending_mask, 32'h0);
        chk("resolve_rs1_bypass", rs1_data, 32'h0000_0077);

        // set wins over clear on same index; bit 0 never sets
        rd_en = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        RegWrite = 1'b1; rd_WB = 5'd7; DataOut_WB = 32'h0000_1234;
        tick();
        idle();
        chk("sb_set_wins", pending_mask, 32'h0000_0080);
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        idle();
        chk("sb_bit0_const", pending_mask, 32'h0000_0080);
        rd_en = 1'b1; rs1_addr = 5'd7;
        tick();
        chk("set_wins_data", rs1_data, 32'h0000_1234);

        // 5. flush ignores issue, still writes the array
        rd_en = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_rd = 5'd9;
        tick();
        chk("sb_pre_flush", pending_mask, 32'h0000_0290);
        flush = 1'b1; issue_rd = 5'd2;
        RegWrite = 1'b1; rd_WB = 5'd4; DataOut_WB = 32'hABCD_EF01;
        tick();
        idle();
        chk("flush_clear", pending_mask, 32'h0);
        rd_en = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd2;
        tick();
        chk("flush_write_x4", rs1_data, 32'hABCD_EF01);
        chk("flush_x2_untouched", rs2_data, 32'h0);

`ifdef WB_REGFILE_WBCOUNT_EN
        // accepted writes so far: x1, x3, x7, x7, x4
        chk("wbcount_5", wb_count, 32'd5);
`endif

        // 6. asynchronous reset mid-operation
        issue_valid = 1'b1; issue_rd = 5'd5;
        RegWrite = 1'b1; rd_WB = 5'd6; DataOut_WB = 32'h5555_AAAA;
        #2 rst = 1'b0;
        #1;
        chk("async_pending", pending_mask, 32'h0);
        chk("async_rs1", rs1_data, 32'h0);
`ifdef WB_REGFILE_WBCOUNT_EN
        chk("async_wbcount", wb_count, 32'd0);
`endif
        tick();
        idle();
        rst = 1'b1;
        rd_en = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd1;
        tick();
        chk("reset_cleared_x4", rs1_data, 32'h0);
        chk("reset_cleared_x1", rs2_data, 32'h0);

`ifdef WB_REGFILE_WBCOUNT_EN
        rd_en = 1'b0;
        RegWrite = 1'b1; rd_WB = 5'd1; DataOut_WB = 32'h1;
        tick();
        rd_WB = 5'd0;
        tick();
        rd_WB = 5'd2;
        tick();
        idle();
        chk("wbcount_2", wb_count, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
